// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider controller.
package clk_div_pkg;

  // Controller states. PEND is RUN with a ratio change waiting for a boundary.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  // Smallest ratio that produces a real high and low phase.
  localparam int DIV_MIN = 2;

  // Length of the high phase for ratio n: ceil(n/2).
  function automatic int unsigned hi_len(input int unsigned n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and waveform generator. The controller decides when the
// counter runs and when a new period starts; this block only counts and
// shapes out_clk so that the high phase comes first and the low phase last.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] ratio,
  input  logic             run,
  input  logic             load,
  output logic             out_clk,
  output logic             tick,
  output logic             boundary
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi;

  // cnt never exceeds ratio-1, so the increment cannot wrap even at the
  // largest ratio.
  assign cnt_inc  = cnt + 1'b1;
  assign hi       = CNT_W'(hi_len(32'(ratio)));
  assign boundary = (cnt == ratio - 1'b1);

  // Counter and registered waveform; a load starts a fresh period with a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      out_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      out_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (load) begin
      cnt     <= '0;
      out_clk <= 1'b1;
      tick    <= 1'b1;
    end else begin
      cnt     <= cnt_inc;
      out_clk <= (cnt_inc < hi);
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop and ratio controller for a programmable integer clock divider.
// Ratio changes are deferred to a period boundary so the divided clock never
// shows a runt or stretched pulse.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             out_clk,
  output logic             tick,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] cur_div
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] pend_div;
  logic             core_boundary;
  logic             counting;
  logic             bnd;
  logic             run;
  logic             load;
  logic             xfer;
  logic             illegal;
  logic             legal_xfer;

  // Handshake: a ratio transfers on any cycle with cfg_valid & cfg_ready.
  // cfg_ready depends only on busy (a register), never on cfg_valid, and
  // stays low while a previously accepted ratio waits for its boundary.
  assign cfg_ready  = !busy;
  assign xfer       = cfg_valid && cfg_ready;
  assign illegal    = (cfg_div < CNT_W'(DIV_MIN));
  assign legal_xfer = xfer && !illegal;

  assign counting = (state != IDLE);
  assign bnd      = counting && core_boundary;
  assign run      = (state_next != IDLE);
  assign load     = run && ((state == IDLE) || bnd);

  // Next-state selection for the run/stop controller.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = en ? RUN : IDLE;
      RUN: begin
        if (!en)             state_next = bnd ? IDLE : STOP;
        else if (legal_xfer) state_next = PEND;
        else                 state_next = RUN;
      end
      PEND: begin
        if (!en)      state_next = bnd ? IDLE : STOP;
        else if (bnd) state_next = RUN;
        else          state_next = PEND;
      end
      STOP: state_next = bnd ? IDLE : STOP;
      default: state_next = IDLE;
    endcase
  end

  // State, ratio registers and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_div  <= CNT_W'(DEFAULT_DIV);
      pend_div <= CNT_W'(DEFAULT_DIV);
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      err   <= xfer && illegal;
      // A pending ratio is applied at the next boundary; if it was accepted
      // on the boundary that returned to IDLE it is applied in IDLE instead.
      if (busy && (bnd || (state == IDLE))) begin
        cur_div <= pend_div;
        busy    <= 1'b0;
      end else if (legal_xfer) begin
        if (state == IDLE) begin
          cur_div <= cfg_div;
        end else begin
          pend_div <= cfg_div;
          busy     <= 1'b1;
        end
      end
    end
  end

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .ratio    (cur_div),
    .run      (run),
    .load     (load),
    .out_clk  (out_clk),
    .tick     (tick),
    .boundary (core_boundary)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: waveform shape, deferred ratio changes,
// illegal ratios, stop/idle sequencing, reset during a pending change and
// the largest ratio.
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             out_clk;
  logic             tick;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] cur_div;

  int   errors = 0;
  int   checks = 0;
  logic exp_prev = 1'b0;

  clk_div_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .out_clk   (out_clk),
    .tick      (tick),
    .busy      (busy),
    .err       (err),
    .cur_div   (cur_div)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One cycle per character; tick is expected on every 0->1 step of out_clk.
  task automatic expect_pat(input string tag, input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      logic eo;
      logic et;
      @(negedge clk);
      eo = (pat[i] == "1");
      et = eo && !exp_prev;
      chk({tag, "_out"}, 32'(out_clk), 32'(eo));
      chk({tag, "_tick"}, 32'(tick), 32'(et));
      exp_prev = eo;
    end
  endtask

  task automatic expect_level(input string tag, input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_out"}, 32'(out_clk), 32'(lvl));
      chk({tag, "_tick"}, 32'(tick), 32'(lvl && !exp_prev));
      exp_prev = lvl;
    end
  endtask

  task automatic chk_status(input string tag, input logic eb, input logic er,
                            input logic ey, input int ed);
    chk({tag, "_busy"}, 32'(busy), 32'(eb));
    chk({tag, "_err"}, 32'(err), 32'(er));
    chk({tag, "_ready"}, 32'(cfg_ready), 32'(ey));
    chk({tag, "_div"}, 32'(cur_div), 32'(ed));
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    chk("rst_out", 32'(out_clk), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b1, 4);

    // Default ratio 4 from one cycle after en.
    en = 1'b1;
    expect_pat("n4", "11001100");
    chk_status("n4", 1'b0, 1'b0, 1'b1, 4);

    // Ratio 6 requested at cnt=1: current period finishes, then 111000.
    expect_pat("n4b", "11");
    cfg_valid = 1'b1;
    cfg_div   = 8'd6;
    expect_pat("to6a", "0");
    cfg_valid = 1'b0;
    chk_status("to6_pend", 1'b1, 1'b0, 1'b0, 4);
    expect_pat("to6b", "0");
    expect_pat("n6a", "1");
    chk_status("n6_applied", 1'b0, 1'b0, 1'b1, 6);
    expect_pat("n6b", "11000111000");

    // Back to ratio 4, requested mid-period.
    expect_pat("n6c", "1");
    cfg_valid = 1'b1;
    cfg_div   = 8'd4;
    expect_pat("to4a", "1");
    cfg_valid = 1'b0;
    expect_pat("to4b", "1000");
    expect_pat("n4c", "1100");
    chk_status("n4c", 1'b0, 1'b0, 1'b1, 4);

    // Ratio 5 sent on the boundary cycle, valid held 3 cycles.
    cfg_valid = 1'b1;
    cfg_div   = 8'd5;
    expect_pat("to5a", "1");
    chk_status("to5_pend", 1'b1, 1'b0, 1'b0, 4);
    expect_pat("to5b", "10");
    cfg_valid = 1'b0;
    expect_pat("to5c", "0");
    expect_pat("n5a", "1");
    chk_status("n5_applied", 1'b0, 1'b0, 1'b1, 5);
    expect_pat("n5b", "110011100");
    chk_status("n5_once", 1'b0, 1'b0, 1'b1, 5);

    // Illegal ratio 1: err pulse, no change, no pending.
    cfg_valid = 1'b1;
    cfg_div   = 8'd1;
    expect_pat("bad1a", "1");
    cfg_valid = 1'b0;
    chk_status("bad1_err", 1'b0, 1'b1, 1'b1, 5);
    expect_pat("bad1b", "1");
    chk_status("bad1_after", 1'b0, 1'b0, 1'b1, 5);

    // en dropped at cnt=1: period completes through STOP, then IDLE.
    en = 1'b0;
    expect_pat("stop", "100000");

    // Ratio 2 in IDLE applies next cycle without busy.
    cfg_valid = 1'b1;
    cfg_div   = 8'd2;
    expect_pat("idle2", "0");
    cfg_valid = 1'b0;
    chk_status("idle2", 1'b0, 1'b0, 1'b1, 2);
    en = 1'b1;
    expect_pat("n2", "101010");
    // en dropped on the boundary: straight to IDLE, no new edge.
    en = 1'b0;
    expect_pat("n2_idle", "000");

    // Reset while a ratio change is pending.
    en = 1'b1;
    expect_pat("n2b", "10");
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    expect_pat("to7", "1");
    cfg_valid = 1'b0;
    chk_status("to7_pend", 1'b1, 1'b0, 1'b0, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("prst_out", 32'(out_clk), 32'd0);
    chk("prst_tick", 32'(tick), 32'd0);
    chk_status("prst", 1'b0, 1'b0, 1'b1, 4);
    exp_prev = 1'b0;
    expect_pat("prst_run", "11001100");
    chk_status("prst_run", 1'b0, 1'b0, 1'b1, 4);

    // Largest ratio: 128 high, 127 low, then wrap.
    en = 1'b0;
    expect_pat("to_idle", "0");
    cfg_valid = 1'b1;
    cfg_div   = 8'd255;
    expect_pat("idle255", "0");
    cfg_valid = 1'b0;
    chk_status("idle255", 1'b0, 1'b0, 1'b1, 255);
    en = 1'b1;
    expect_level("n255_hi", 1'b1, 128);
    expect_level("n255_lo", 1'b0, 127);
    expect_level("n255_wrap", 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run/stop and ratio controller for a programmable integer clock divider.
- Generates a divided clock `out_clk` and a rising-edge `tick` pulse.
- Accepts new divide ratios over a valid/ready handshake and applies them only at a period boundary, so no runt or stretched pulse is ever produced.
- Sits between the clock-configuration register logic and any logic clocked or enabled by the divided output.

Parameters:
- CNT_W, 8: width of the divide ratio and of the internal period counter.
- DEFAULT_DIV, 4: divide ratio loaded at reset; must be ≥2 and <2**CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request; level-sensitive.
- cfg_valid  in  1  new-ratio request valid.
- cfg_div  in  CNT_W  requested divide ratio N.
- cfg_ready  out  1  controller can accept a ratio this cycle.
- out_clk  out  1  divided clock; registered.
- tick  out  1  one-cycle pulse, high in the same cycle `out_clk` rises; registered.
- busy  out  1  a ratio change is pending.
- err  out  1  one-cycle pulse: accepted ratio was illegal (<2).
- cur_div  out  CNT_W  ratio currently in effect.

Behaviour:
- Reset (clk edge with rst=1) sets: out_clk=0, tick=0, err=0, busy=0, cfg_ready=1, cur_div=DEFAULT_DIV, cnt=0, state=IDLE. Reset mid-operation discards any pending ratio.
- Waveform for ratio N:
  - cnt runs 0..N-1 and wraps.
  - out_clk is registered as (cnt_next < N-(N>>1)), so it is high for ceil(N/2) cycles, then low for floor(N/2) cycles.
  - N=4 gives 1100, N=5 gives 11100, N=2 gives 10.
- States: IDLE, RUN, PEND, STOP.
- IDLE:
  - out_clk=0, cnt held at 0.
  - When en=1: next cycle enter RUN with cnt=0, out_clk=1, tick=1. First rising edge is 1 cycle after en is sampled.
- RUN:
  - Counts.
  - At boundary (cnt==cur_div-1): next cnt=0, out_clk=1, tick=1.
  - en=0 sampled with cnt≠N-1 → STOP.
  - en=0 at the boundary → IDLE directly, with no new rising edge.
- STOP:
  - Completes the current period; en is ignored.
  - At the boundary → IDLE, out_clk stays 0 and no tick. Low phase is last, so out_clk is already 0.
- Handshake:
  - A transfer occurs when cfg_valid & cfg_ready.
  - cfg_ready = !busy (high in IDLE, RUN and STOP when nothing is pending).
  - cfg_div<2: transfer completes, err=1 the next cycle, cur_div unchanged, no pending change.
- Legal ratio in IDLE: cur_div updates the next cycle; busy never asserts.
- Legal ratio in RUN or STOP:
  - Latched into pend_div; busy=1 and cfg_ready=0 from the next cycle.
  - Pending ratio is applied at the next boundary: cur_div=pend_div and cnt=0 in the same edge that raises out_clk. busy clears on that edge.
  - If the transfer cycle is itself a boundary cycle, the ratio is NOT applied at that boundary; it is applied at the following one.
  - A STOP or IDLE transition also applies the pending ratio at its boundary.
  - PEND tracks the RUN-with-pending condition; en=0 in PEND behaves as in RUN.
- Simultaneous en=0 and a cfg transfer: both take effect as above, independently.
- Ratio 2**CNT_W-1 must work; the counter must not overflow.

Decomposition:
- Package clk_div_pkg:
  - state enum {IDLE, RUN, PEND, STOP}.
  - constant DIV_MIN=2.
  - function hi_len(N) = N-(N>>1).
- Sub-module clk_div_core:
  - Contains the counter and waveform generator.
  - Inputs: ratio, run, load strobe.
  - Outputs: out_clk, tick, boundary flag.
- The top module holds the FSM, handshake and pend_div register.

Test Plan:
- rst 2 cycles, en=1, default 4 → out_clk 1100 repeating from 1 cycle after en; tick every 4 cycles; cur_div=4.
- In RUN at cnt=1, send cfg_div=6 → busy=1, cfg_ready=0; current period completes 1100, then 111000 repeating; busy clears on the first rising edge at N=6.
- Send cfg_div=5 in the boundary cycle (cnt=3, N=4) → one more 1100 period, then 11100; check transfer with cfg_valid held 3 cycles completes once.
- cfg_div=1 in RUN → err pulse 1 cycle, cur_div stays 4, busy never asserts; cfg_div=2 in IDLE → cur_div=2 next cycle, then en gives 10 pattern.
- en dropped at cnt=1 → waveform completes (0 at cnt 2,3), then IDLE with out_clk=0 and no further tick; en raised again → tick 1 cycle later.
- Assert rst during PEND → next cycle cur_div=DEFAULT_DIV, busy=0, out_clk=0, cfg_ready=1; pending ratio is never applied.
